// File: rtl/router_pkg.sv
// Shared types and constants for the router control path: FSM state
// encoding, output-port addresses and the per-port flag selector.
package router_pkg;

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      FIFO_FULL_STATE    = 3'd3,
      LOAD_AFTER_FULL    = 3'd4,
      LOAD_PARITY        = 3'd5,
      CHECK_PARITY_ERROR = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   localparam logic [1:0] PORT_0       = 2'd0;
   localparam logic [1:0] PORT_1       = 2'd1;
   localparam logic [1:0] PORT_2       = 2'd2;
   localparam logic [1:0] ADDR_INVALID = 2'd3;

   // Picks the flag belonging to one output port; the invalid address reads as 0.
   function automatic logic port_sel(input logic [2:0] flags, input logic [1:0] addr);
      logic result;
      case (addr)
         PORT_0:  result = flags[0];
         PORT_1:  result = flags[1];
         PORT_2:  result = flags[2];
         default: result = 1'b0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload and
// parity loads, and stalls the source while the selected FIFO is busy or full.
module router_fsm
   import router_pkg::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       pkt_valid,
   input  logic [1:0] data_in,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_add,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy
);

   state_t     state_r;
   state_t     next_s;
   logic [1:0] addr_r;
   logic [2:0] empty_vec_s;
   logic [2:0] soft_vec_s;
   logic       hdr_empty_s;
   logic       addr_empty_s;
   logic       soft_sel_s;

   assign empty_vec_s = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign soft_vec_s  = {soft_reset_2, soft_reset_1, soft_reset_0};

   // Per-port flag selection: header address in DA, latched address afterwards.
   always_comb begin
      hdr_empty_s  = port_sel(empty_vec_s, data_in);
      addr_empty_s = port_sel(empty_vec_s, addr_r);
      soft_sel_s   = port_sel(soft_vec_s, addr_r);
   end

   // Next-state selection; a timeout on the active port beats every other exit.
   always_comb begin
      next_s = state_r;
      if ((state_r != DECODE_ADDRESS) && soft_sel_s) begin
         next_s = DECODE_ADDRESS;
      end else begin
         case (state_r)
            DECODE_ADDRESS: begin
               if (pkt_valid && (data_in != ADDR_INVALID)) begin
                  next_s = hdr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
               end else begin
                  next_s = DECODE_ADDRESS;
               end
            end
            WAIT_TILL_EMPTY:    next_s = addr_empty_s ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:    next_s = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full) begin
                  next_s = FIFO_FULL_STATE;
               end else if (!pkt_valid) begin
                  next_s = LOAD_PARITY;
               end else begin
                  next_s = LOAD_DATA;
               end
            end
            FIFO_FULL_STATE:    next_s = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
            LOAD_AFTER_FULL: begin
               if (parity_done) begin
                  next_s = DECODE_ADDRESS;
               end else if (low_pkt_valid) begin
                  next_s = LOAD_PARITY;
               end else begin
                  next_s = LOAD_DATA;
               end
            end
            LOAD_PARITY:        next_s = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_s = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            next_s = DECODE_ADDRESS;
         endcase
      end
   end

   // State, latched port address, and Moore outputs decoded from the next state
   // so each output flop mirrors the state register exactly.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_r       <= DECODE_ADDRESS;
         addr_r        <= PORT_0;
         detect_add    <= 1'b1;
         lfd_state     <= 1'b0;
         ld_state      <= 1'b0;
         laf_state     <= 1'b0;
         full_state    <= 1'b0;
         rst_int_reg   <= 1'b0;
         write_enb_reg <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state_r <= next_s;
         if ((state_r == DECODE_ADDRESS) && (next_s != DECODE_ADDRESS)) begin
            addr_r <= data_in;
         end else begin
            addr_r <= addr_r;
         end
         detect_add    <= (next_s == DECODE_ADDRESS);
         lfd_state     <= (next_s == LOAD_FIRST_DATA);
         ld_state      <= (next_s == LOAD_DATA);
         laf_state     <= (next_s == LOAD_AFTER_FULL);
         full_state    <= (next_s == FIFO_FULL_STATE);
         rst_int_reg   <= (next_s == CHECK_PARITY_ERROR);
         write_enb_reg <= (next_s inside {LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL});
         busy          <= (next_s inside {LOAD_FIRST_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL,
                                          LOAD_PARITY, CHECK_PARITY_ERROR, WAIT_TILL_EMPTY});
      end
   end

endmodule
